// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between two req/ack masters.
//   Port 0 is the CPU, port 1 is the loader/debug master.
//   Only one transaction is in flight at a time: IDLE -> BUSY -> ACK -> IDLE.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   : round-robin on a tie (the port that did not win
//                              last time wins; port 0 wins the first tie after
//                              reset).
//                  undefined : fixed priority, port 0 always wins a tie.
//
// Handshake (both master ports): a master raises req and holds rw/addr/wdata
// stable while req is high. The arbiter answers with a single-cycle ack, and
// rdata is meaningful only in that ack cycle. The master drops req in the
// cycle after ack; a req still high in the following IDLE cycle is taken as a
// new transaction. Req changes while the arbiter is BUSY or in ACK are ignored.
//
// o_dbg_state exposes the FSM state (0=IDLE, 1=BUSY, 2=ACK) for checkers.

module mem_arbiter #(
    parameter int LATENCY = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          i_reset,

    input  logic          i_p0_req,
    input  logic          i_p0_rw,
    input  logic [AW-1:0] i_p0_addr,
    input  logic [DW-1:0] i_p0_wdata,
    output logic          o_p0_ack,
    output logic [DW-1:0] o_p0_rdata,

    input  logic          i_p1_req,
    input  logic          i_p1_rw,
    input  logic [AW-1:0] i_p1_addr,
    input  logic [DW-1:0] i_p1_wdata,
    output logic          o_p1_ack,
    output logic [DW-1:0] o_p1_rdata,

    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_rw,
    input  logic [DW-1:0] i_mem_rdata,

    output logic          o_busy,
    output logic          o_owner,
    output logic [1:0]    o_dbg_state
);

    // Counter wide enough to hold LATENCY itself.
    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   rdata_q;

    logic            any_req;
    logic            grant_port;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_rw;

`ifdef MEM_ARB_RR_EN
    logic            last_grant;
`endif

    // Winner selection for the IDLE cycle and the request fields it carries.
    always_comb begin
        any_req = i_p0_req | i_p1_req;
`ifdef MEM_ARB_RR_EN
        if (i_p0_req && i_p1_req) begin
            grant_port = ~last_grant;
        end else begin
            grant_port = ~i_p0_req;
        end
`else
        grant_port = ~i_p0_req;
`endif
        if (grant_port) begin
            sel_addr  = i_p1_addr;
            sel_wdata = i_p1_wdata;
            sel_rw    = i_p1_rw;
        end else begin
            sel_addr  = i_p0_addr;
            sel_wdata = i_p0_wdata;
            sel_rw    = i_p0_rw;
        end
    end

    // FSM with registered memory-side and master-side outputs.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_rw    <= 1'b0;
            o_p0_ack    <= 1'b0;
            o_p1_ack    <= 1'b0;
            rdata_q     <= '0;
            o_busy      <= 1'b0;
            o_owner     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant  <= 1'b1;
`endif
        end else begin
            // Strobes and acks are single-cycle unless set again below.
            o_mem_rw <= 1'b0;
            o_p0_ack <= 1'b0;
            o_p1_ack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        o_mem_addr  <= sel_addr;
                        o_mem_wdata <= sel_wdata;
                        o_mem_rw    <= sel_rw;
                        o_owner     <= grant_port;
                        cnt         <= CW'(LATENCY);
                        o_busy      <= 1'b1;
                        state       <= ST_BUSY;
`ifdef MEM_ARB_RR_EN
                        last_grant  <= grant_port;
`endif
                    end
                end

                ST_BUSY: begin
                    // Address has been stable since entry; read data is due
                    // exactly when the counter reaches zero.
                    if (cnt == '0) begin
                        rdata_q <= i_mem_rdata;
                        if (o_owner) begin
                            o_p1_ack <= 1'b1;
                        end else begin
                            o_p0_ack <= 1'b1;
                        end
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_ACK: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Both ports see the captured word; it is meaningful only with ack.
    assign o_p0_rdata  = rdata_q;
    assign o_p1_rdata  = rdata_q;
    assign o_dbg_state = state;

endmodule
